spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_ctrl_pkg.sv | 25 ++
 rtl/spi_master_ctrl_if.sv | 26 ++
 rtl/spi_shift_reg.sv | 39 +++
 rtl/spi_master_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI master controller.
// Holds the FSM state encoding, the 2-bit frame command codes and a helper
// that builds one 10-bit SPI word {cmd, payload}.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEL       = 3'd1,
    SHIFT     = 3'd2,
    GAP       = 3'd3,
    WAIT_MISO = 3'd4,
    CAPTURE   = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic [9:0] make_word(input logic [1:0] cmd, input logic [7:0] payload);
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side request/response bus of the SPI master controller.
//   req_valid/req_ready : request handshake
//   req_wr/addr/wdata   : request contents (1 = write, 0 = read)
//   rsp_valid/rsp_rdata : one-cycle completion pulse and read data
//   busy                : operation in progress
// modport master: the host; modport slave: the controller.
interface spi_master_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_shift_reg.sv
// SPI data path: 10-bit parallel-load transmit register shifted out MSB
// first, and an 8-bit receive register shifted in MSB first.
//   load/load_word : parallel load of the transmit word (wins over shift)
//   shift_out      : advance the transmit word by one bit
//   shift_in/sin   : append one received bit
//   sout           : current transmit bit (word MSB)
//   rx             : received byte
// Pure data storage; no reset needed since the controller gates its use.
module spi_shift_reg (
  input  logic       clk,
  input  logic       load,
  input  logic [9:0] load_word,
  input  logic       shift_out,
  input  logic       shift_in,
  input  logic       sin,
  output logic       sout,
  output logic [7:0] rx
);

  logic [9:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;

  always_comb begin
    tx_d = tx_q;
    if (load)           tx_d = load_word;
    else if (shift_out) tx_d = {tx_q[8:0], 1'b0};
    rx_d = rx_q;
    if (shift_in)       rx_d = {rx_q[6:0], sin};
  end

  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign sout = tx_q[9];
  assign rx   = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: turns one host request into two 10-bit SPI frames
// (address frame, then data frame) and, for reads, waits MISO_DELAY cycles
// and captures 8 MISO bits.
//   clk, rst_n     : clock, synchronous active-low reset
//   host           : request/response bus (slave side)
//   SS_n/MOSI/MISO : SPI pins
// Parameters: GAP_CYCLES (1..15) SS_n-high cycles between frames,
//             MISO_DELAY (0..15) wait cycles before the first MISO sample.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int MISO_DELAY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_ctrl_if.slave   host,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  // Unreachable value when MISO_DELAY is 0; WAIT_MISO is then skipped.
  localparam logic [3:0] WAIT_LAST = 4'(MISO_DELAY - 1);

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] dly_cnt_q, dly_cnt_d;
  logic       frame_q, frame_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;

  logic       sr_load, sr_shift, rx_shift, sr_out;
  logic [9:0] sr_word;
  logic [7:0] rx_byte;
  logic       ready, accept;
  logic       ss_n, mosi, rsp_valid, busy;

  spi_shift_reg u_sr (
    .clk       (clk),
    .load      (sr_load),
    .load_word (sr_word),
    .shift_out (sr_shift),
    .shift_in  (rx_shift),
    .sin       (MISO),
    .sout      (sr_out),
    .rx        (rx_byte)
  );

  // Ready is masked by rst_n so it reads 0 while reset is asserted.
  assign ready  = (state_q == IDLE) && rst_n;
  assign accept = host.req_valid && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      dly_cnt_q <= '0;
      frame_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      frame_q   <= frame_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dly_cnt_d = dly_cnt_q;
    frame_d   = frame_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    sr_load   = 1'b0;
    sr_word   = '0;
    sr_shift  = 1'b0;
    rx_shift  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        // Frame 1 is loaded straight from the request inputs.
        state_d = SEL;
        wr_d    = host.req_wr;
        wdata_d = host.req_wdata;
        frame_d = 1'b0;
        sr_load = 1'b1;
        sr_word = make_word(host.req_wr ? CMD_WR_ADDR : CMD_RD_ADDR, host.req_addr);
      end
      // The select cycle already shows word[9]; shifting starts after SHIFT's first cycle.
      SEL: begin
        state_d   = SHIFT;
        bit_cnt_d = '0;
      end
      SHIFT: begin
        sr_shift = 1'b1;
        if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = '0;
          dly_cnt_d = '0;
          if (!frame_q)             state_d = GAP;
          else if (wr_q)            state_d = DONE;
          else if (MISO_DELAY == 0) state_d = CAPTURE;
          else                      state_d = WAIT_MISO;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      GAP: if (dly_cnt_q == GAP_LAST) begin
        dly_cnt_d = '0;
        state_d   = SEL;
        frame_d   = 1'b1;
        sr_load   = 1'b1;
        sr_word   = wr_q ? make_word(CMD_WR_DATA, wdata_q) : make_word(CMD_RD_DATA, 8'h00);
      end else begin
        dly_cnt_d = dly_cnt_q + 4'd1;
      end
      WAIT_MISO: if (dly_cnt_q == WAIT_LAST) begin
        dly_cnt_d = '0;
        state_d   = CAPTURE;
      end else begin
        dly_cnt_d = dly_cnt_q + 4'd1;
      end
      CAPTURE: begin
        rx_shift = 1'b1;
        if (bit_cnt_q == 4'd7) begin
          bit_cnt_d = '0;
          state_d   = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!wr_q) rdata_d = rx_byte;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ss_n      = 1'b1;
    mosi      = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      SEL, SHIFT:         begin ss_n = 1'b0; mosi = sr_out; end
      WAIT_MISO, CAPTURE: ss_n = 1'b0;
      DONE:               rsp_valid = 1'b1;
      default:            ;
    endcase
  end

  assign SS_n           = ss_n;
  assign MOSI           = mosi;
  assign host.req_ready = ready;
  assign host.rsp_valid = rsp_valid;
  assign host.busy      = busy;
  // During the completion cycle the freshly captured byte is presented directly.
  assign host.rsp_rdata = (state_q == DONE && !wr_q) ? rx_byte : rdata_q;

endmodule
